s4ga_cfg_seq: RTL and testbench

Configuration sequencer for the s4ga LUT-array core. Captures one complete bitstream of N LUT frames, LL segments of SI_W bits each, into an internal segment store through a ready/valid load port. It then holds the core in reset for a programmable number of cycles and replays the store to the core's si input, one segment per clock, in an endless loop. It pulses a marker each time a full pass of all N LUTs completes, which is the cycle the core updates its outputs.

---
 rtl/s4ga_cfg_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_s4ga_cfg_seq.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/s4ga_cfg_seq.sv
// s4ga_cfg_seq: configuration sequencer for the s4ga LUT-array core.
// Captures one bitstream into a segment store over a ready/valid port, holds the
// core in reset for RST_CYCLES, then replays the store on si in an endless loop.
// Optional feature macro: S4GA_CFG_SEQ_CKSUM_EN (trailing XOR checksum segment).
module s4ga_cfg_seq #(
   parameter int N          = 16,
   parameter int K          = 4,
   parameter int SI_W       = 4,
   parameter int RST_CYCLES = 20,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld_valid,
   output logic             ld_ready,
   input  logic [SI_W-1:0]  ld_data,
   input  logic             ld_last,
   input  logic             start,
   input  logic             stop,
   output logic             fpga_rst,
   output logic [SI_W-1:0]  si,
   output logic             running,
   output logic             cfg_valid,
   output logic             load_err,
   output logic             pass_done,
   output logic [CNT_W-1:0] pass_cnt
);

   localparam int IDX_SEGS  = ($clog2(N) + SI_W - 1) / SI_W;
   localparam int MASK_SEGS = ((1 << K) + SI_W - 1) / SI_W;
   localparam int LL        = K * IDX_SEGS + MASK_SEGS;
   localparam int DEPTH     = N * LL;
   localparam int PTR_W     = $clog2(DEPTH);
   localparam int HCNT_W    = $clog2(RST_CYCLES + 1);

   localparam logic [PTR_W-1:0]  LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [HCNT_W-1:0] HOLD_END = HCNT_W'(RST_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   wptr_q, wptr_d;
   logic               full_q, full_d;
   logic [PTR_W-1:0]   rptr_q, rptr_d;
   logic [HCNT_W-1:0]  hcnt_q, hcnt_d;
   logic               ld_ready_q, ld_ready_d;
   logic               fpga_rst_q, fpga_rst_d;
   logic [SI_W-1:0]    si_q, si_d;
   logic               running_q, running_d;
   logic               cfg_valid_q, cfg_valid_d;
   logic               load_err_q, load_err_d;
   logic               pass_done_q, pass_done_d;
   logic [CNT_W-1:0]   pass_cnt_q, pass_cnt_d;
`ifdef S4GA_CFG_SEQ_CKSUM_EN
   logic [SI_W-1:0]    cksum_q, cksum_d;
`endif

   logic [SI_W-1:0]    mem [DEPTH];
   logic               mem_we;
   logic [PTR_W-1:0]   mem_waddr;
   logic               accept;

   assign accept = ld_valid & ld_ready_q;

   // Next-state logic: load bookkeeping, hold countdown and stream replay.
   // full_q marks that segment DEPTH-1 has been stored without ld_last, so the
   // next accepted segment is either the checksum or an overflow.
   always_comb begin
      state_d     = state_q;
      wptr_d      = wptr_q;
      full_d      = full_q;
      rptr_d      = rptr_q;
      hcnt_d      = hcnt_q;
      cfg_valid_d = cfg_valid_q;
      load_err_d  = load_err_q;
      pass_cnt_d  = pass_cnt_q;
      pass_done_d = 1'b0;
      fpga_rst_d  = 1'b1;
      si_d        = '0;
      mem_we      = 1'b0;
      mem_waddr   = wptr_q;
`ifdef S4GA_CFG_SEQ_CKSUM_EN
      cksum_d     = cksum_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               mem_we      = 1'b1;
               mem_waddr   = '0;
               wptr_d      = PTR_W'(1);
               full_d      = 1'b0;
               cfg_valid_d = 1'b0;
               load_err_d  = 1'b0;
`ifdef S4GA_CFG_SEQ_CKSUM_EN
               cksum_d     = ld_data;
`endif
               if (ld_last) begin
                  load_err_d = 1'b1;
               end else begin
                  state_d = LOAD;
               end
            end else if (start && cfg_valid_q) begin
               state_d = HOLD;
               hcnt_d  = '0;
               rptr_d  = '0;
            end
         end
         LOAD: begin
            if (accept) begin
               if (!full_q) begin
                  mem_we = 1'b1;
`ifdef S4GA_CFG_SEQ_CKSUM_EN
                  cksum_d = cksum_q ^ ld_data;
`endif
                  if (wptr_q == LAST_PTR) begin
                     if (ld_last) begin
`ifdef S4GA_CFG_SEQ_CKSUM_EN
                        load_err_d  = 1'b1;
`else
                        cfg_valid_d = 1'b1;
`endif
                        state_d = IDLE;
                     end else begin
                        full_d = 1'b1;
                     end
                  end else if (ld_last) begin
                     load_err_d = 1'b1;
                     state_d    = IDLE;
                  end else begin
                     wptr_d = wptr_q + PTR_W'(1);
                  end
               end else begin
                  state_d = IDLE;
`ifdef S4GA_CFG_SEQ_CKSUM_EN
                  if (ld_last && (ld_data == cksum_q)) begin
                     cfg_valid_d = 1'b1;
                  end else begin
                     load_err_d = 1'b1;
                  end
`else
                  load_err_d = 1'b1;
`endif
               end
            end
         end
         HOLD: begin
            if (stop) begin
               state_d = IDLE;
            end else if (hcnt_q == HOLD_END) begin
               state_d    = RUN;
               pass_cnt_d = '0;
               fpga_rst_d = 1'b0;
               si_d       = mem[rptr_q];
               rptr_d     = rptr_q + PTR_W'(1);
            end else begin
               hcnt_d = hcnt_q + HCNT_W'(1);
            end
         end
         RUN: begin
            if (stop) begin
               state_d = IDLE;
            end else begin
               fpga_rst_d = 1'b0;
               si_d       = mem[rptr_q];
               if (rptr_q == LAST_PTR) begin
                  rptr_d      = '0;
                  pass_done_d = 1'b1;
                  pass_cnt_d  = pass_cnt_q + CNT_W'(1);
               end else begin
                  rptr_d = rptr_q + PTR_W'(1);
               end
            end
         end
      endcase
      ld_ready_d = (state_d == IDLE) || (state_d == LOAD);
      running_d  = (state_d == RUN);
   end

   // State and registered outputs; store contents are deliberately not reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         wptr_q      <= '0;
         full_q      <= 1'b0;
         rptr_q      <= '0;
         hcnt_q      <= '0;
         ld_ready_q  <= 1'b0;
         fpga_rst_q  <= 1'b1;
         si_q        <= '0;
         running_q   <= 1'b0;
         cfg_valid_q <= 1'b0;
         load_err_q  <= 1'b0;
         pass_done_q <= 1'b0;
         pass_cnt_q  <= '0;
`ifdef S4GA_CFG_SEQ_CKSUM_EN
         cksum_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         full_q      <= full_d;
         rptr_q      <= rptr_d;
         hcnt_q      <= hcnt_d;
         ld_ready_q  <= ld_ready_d;
         fpga_rst_q  <= fpga_rst_d;
         si_q        <= si_d;
         running_q   <= running_d;
         cfg_valid_q <= cfg_valid_d;
         load_err_q  <= load_err_d;
         pass_done_q <= pass_done_d;
         pass_cnt_q  <= pass_cnt_d;
`ifdef S4GA_CFG_SEQ_CKSUM_EN
         cksum_q     <= cksum_d;
`endif
      end
   end

   // Segment store write port, one segment per accepted load beat.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= ld_data;
      end
   end

   assign ld_ready  = ld_ready_q;
   assign fpga_rst  = fpga_rst_q;
   assign si        = si_q;
   assign running   = running_q;
   assign cfg_valid = cfg_valid_q;
   assign load_err  = load_err_q;
   assign pass_done = pass_done_q;
   assign pass_cnt  = pass_cnt_q;

endmodule

// File: tb/tb_s4ga_cfg_seq.sv
// tb_s4ga_cfg_seq: self-checking bench for s4ga_cfg_seq.
// Load outcomes come from a table of load scenarios; the replay stream is
// predicted from a model store indexed by cycle count since entering RUN.
module tb_s4ga_cfg_seq;

   localparam int SI_W       = 4;
   localparam int CNT_W      = 16;
   localparam int RST_CYCLES = 20;
   localparam int DEPTH      = 128;
`ifdef S4GA_CFG_SEQ_CKSUM_EN
   localparam int CK = 1;
`else
   localparam int CK = 0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             ld_valid = 1'b0;
   logic             ld_last = 1'b0;
   logic             start = 1'b0;
   logic             stop = 1'b0;
   logic [SI_W-1:0]  ld_data = '0;
   logic             ld_ready, fpga_rst, running, cfg_valid, load_err, pass_done;
   logic [SI_W-1:0]  si;
   logic [CNT_W-1:0] pass_cnt;

   int checks = 0;
   int failures = 0;

   logic [SI_W-1:0] modelStore [DEPTH];

   typedef struct {
      string name;
      int    nSeg;
      int    lastAt;
      bit    badCk;
      bit    expValid;
      bit    expErr;
   } loadVec_t;

   loadVec_t vecs[$];

   s4ga_cfg_seq #(
      .N(16), .K(4), .SI_W(SI_W), .RST_CYCLES(RST_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
      .start(start), .stop(stop),
      .fpga_rst(fpga_rst), .si(si), .running(running),
      .cfg_valid(cfg_valid), .load_err(load_err),
      .pass_done(pass_done), .pass_cnt(pass_cnt)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // One load beat; random idle gap before it, random start/stop alongside it.
   task automatic sendSeg(input logic [SI_W-1:0] d, input bit last);
      int guard;
      guard = 0;
      if ($urandom_range(3) == 0) begin
         ld_valid = 1'b0;
         step();
      end
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      start    = 1'($urandom_range(1));
      stop     = 1'($urandom_range(1));
      while (!ld_ready && guard < 20) begin
         step();
         guard++;
      end
      checkOutput("ld_ready_beat", 32'(ld_ready), 32'd1);
      step();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      start    = 1'b0;
      stop     = 1'b0;
   endtask

   // Streams a bitstream: data segments, optional checksum, optional extra.
   task automatic applyStimulus(input int nSeg, input int lastAt, input bit badCk, input bit randData);
      logic [SI_W-1:0] d;
      logic [SI_W-1:0] x;
      x = '0;
      for (int i = 0; i < nSeg; i++) begin
         if (i < DEPTH) begin
            d = randData ? SI_W'($urandom) : SI_W'(i);
            x = x ^ d;
            modelStore[i] = d;
         end else if (i == DEPTH && CK == 1) begin
            d = x ^ SI_W'(badCk);
         end else begin
            d = SI_W'($urandom);
         end
         sendSeg(d, i == lastAt);
      end
   endtask

   task automatic startTry();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic measureHold();
      int n;
      n = 0;
      while (fpga_rst && n < 100) begin
         n++;
         step();
      end
      checkOutput("hold_cycles", 32'(n), 32'(RST_CYCLES));
   endtask

   // Cycle t of RUN shows store[t mod DEPTH]; a pass completes every DEPTH cycles.
   task automatic runCheck(input int cycles);
      for (int t = 0; t < cycles; t++) begin
         logic [SI_W-1:0]  expSi;
         logic             expDone;
         logic [CNT_W-1:0] expCnt;
         expSi   = modelStore[t % DEPTH];
         expDone = ((t % DEPTH) == DEPTH - 1);
         expCnt  = CNT_W'((t + 1) / DEPTH);
         checkOutput("run_stream",
                     {9'b0, fpga_rst, running, si, pass_done, pass_cnt},
                     {9'b0, 1'b0, 1'b1, expSi, expDone, expCnt});
         step();
      end
   endtask

   initial begin
      #12;
      checkOutput("reset_values",
                  {8'b0, ld_ready, fpga_rst, si, running, cfg_valid, load_err, pass_done, pass_cnt},
                  {8'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0});
      #8;
      rst = 1'b0;
      step();
      checkOutput("idle_ready", 32'(ld_ready), 32'd1);
      startTry();
      repeat (3) step();
      checkOutput("start_no_cfg", {30'b0, ld_ready, fpga_rst}, {30'b0, 1'b1, 1'b1});

      vecs.push_back('{"full",       DEPTH + CK,  DEPTH - 1 + CK, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{"short50",    51,          50,             1'b0, 1'b0, 1'b1});
      vecs.push_back('{"single",     1,           0,              1'b0, 1'b0, 1'b1});
      vecs.push_back('{"full2",      DEPTH + CK,  DEPTH - 1 + CK, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{"overflow",   DEPTH + 1,   -1,             1'b0, 1'b0, 1'b1});
      vecs.push_back('{"lastAtM2",   DEPTH - 1,   DEPTH - 2,      1'b0, 1'b0, 1'b1});
      vecs.push_back('{"lastAtM1",   DEPTH,       DEPTH - 1,      1'b0, 1'(CK == 0), 1'(CK == 1)});
`ifdef S4GA_CFG_SEQ_CKSUM_EN
      vecs.push_back('{"badCksum",   DEPTH + 1,   DEPTH,          1'b1, 1'b0, 1'b1});
      vecs.push_back('{"goodCksum",  DEPTH + 1,   DEPTH,          1'b0, 1'b1, 1'b0});
`endif

      foreach (vecs[v]) begin
         applyStimulus(vecs[v].nSeg, vecs[v].lastAt, vecs[v].badCk, 1'b1);
         checkOutput({vecs[v].name, "_flags"},
                     {29'b0, ld_ready, cfg_valid, load_err},
                     {29'b0, 1'b1, vecs[v].expValid, vecs[v].expErr});
         startTry();
         checkOutput({vecs[v].name, "_start"}, {30'b0, ld_ready, fpga_rst},
                     {30'b0, !vecs[v].expValid, 1'b1});
         if (vecs[v].expValid) begin
            stop = 1'b1;
            step();
            stop = 1'b0;
            checkOutput({vecs[v].name, "_stop_hold"}, 32'(ld_ready), 32'd1);
         end else begin
            repeat (RST_CYCLES + 5) step();
            checkOutput({vecs[v].name, "_no_run"}, {30'b0, fpga_rst, running}, {30'b0, 1'b1, 1'b0});
         end
      end

      applyStimulus(DEPTH + CK, DEPTH - 1 + CK, 1'b0, 1'b0);
      checkOutput("pattern_valid", {30'b0, cfg_valid, load_err}, {30'b0, 1'b1, 1'b0});
      startTry();
      measureHold();
      runCheck(2 * DEPTH + 70);
      stop = 1'b1;
      step();
      stop = 1'b0;
      checkOutput("stop_mid_run",
                  {9'b0, fpga_rst, running, si, pass_done, pass_cnt},
                  {9'b0, 1'b1, 1'b0, 4'h0, 1'b0, 16'd2});
      startTry();
      measureHold();
      runCheck(DEPTH + 10);

      #2;
      rst = 1'b1;
      #1;
      checkOutput("async_reset",
                  {8'b0, ld_ready, fpga_rst, si, running, cfg_valid, load_err, pass_done, pass_cnt},
                  {8'b0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0});
      #1;
      rst = 1'b0;
      step();
      startTry();
      repeat (RST_CYCLES + 5) step();
      checkOutput("start_after_reset",
                  {29'b0, ld_ready, fpga_rst, running}, {29'b0, 1'b1, 1'b1, 1'b0});

      applyStimulus(DEPTH + CK, DEPTH - 1 + CK, 1'b0, 1'b1);
      checkOutput("random_valid", {30'b0, cfg_valid, load_err}, {30'b0, 1'b1, 1'b0});
      startTry();
      measureHold();
      runCheck(2 * DEPTH + 5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
